// File: rtl/keycode_event_queue_pkg.sv
// Shared types and default constants for the keycode event queue:
// the event record, the press/release FSM states and parameter defaults.
package keycode_pkg;

    localparam int STABLE_CYCLES_DEFAULT = 4;
    localparam int DEPTH_DEFAULT         = 8;

    typedef struct packed {
        logic [7:0] code;
        logic       make;
    } key_event_t;

    typedef enum logic [1:0] {
        IDLE,
        REL,
        PRS
    } fsm_state_t;

endpackage

// File: rtl/keycode_event_queue_if.sv
// Valid/ready event stream carrying one keycode event per transfer.
interface keycode_event_queue_if;

    logic       ev_valid;
    logic       ev_ready;
    logic [7:0] ev_code;
    logic       ev_make;

    modport master (output ev_valid, output ev_code, output ev_make, input ev_ready);
    modport slave  (input ev_valid, input ev_code, input ev_make, output ev_ready);

endinterface

// File: rtl/keycode_event_queue_fifo.sv
// First-word-fallthrough event FIFO; the head is read straight out of storage.
module event_fifo
    import keycode_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEFAULT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push,
    input  key_event_t push_data,
    input  logic       pop,
    output key_event_t head,
    output logic       full,
    output logic       empty,
    output logic [4:0] count
);

    localparam int PTR_W = $clog2(DEPTH);

    key_event_t       mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    // A full FIFO still accepts a write when the head leaves on the same edge.
    assign empty   = (count == 5'd0);
    assign full    = (count == 5'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= 5'd0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 5'd1;
                2'b01:   count <= count - 5'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/keycode_event_queue.sv
// Debounces the PIO keycode and turns each accepted change into release/press
// events queued for a valid/ready consumer.
module keycode_event_queue
    import keycode_pkg::*;
#(
    parameter int STABLE_CYCLES = STABLE_CYCLES_DEFAULT,
    parameter int DEPTH         = DEPTH_DEFAULT
) (
    input  logic                   Clk,
    input  logic                   Reset_n,
    input  logic [7:0]             keycode,
    keycode_event_queue_if.master  ev,
    output logic [4:0]             count,
    output logic                   overflow,
    input  logic                   clr_overflow,
    output logic [7:0]             last_code
);

    fsm_state_t state;
    fsm_state_t next_state;
    logic [7:0] cand;
    logic [3:0] cnt;
    logic [3:0] cnt_next;
    logic [7:0] accepted;
    logic [7:0] prev_code;
    logic       matured;
    logic       accept;
    logic       push;
    key_event_t push_data;
    key_event_t head;
    logic       pop;
    logic       full;
    logic       empty;
    logic       dropped;

    // Acceptance looks at the count this edge will produce, so a code held
    // from edge 1 is accepted on edge STABLE_CYCLES and pushed one edge later.
    always_comb begin
        cnt_next = 4'd0;
        if (keycode == cand) begin
            cnt_next = (cnt == 4'(STABLE_CYCLES)) ? cnt : cnt + 4'd1;
        end
    end

    assign matured = (keycode == cand) && (cnt_next >= 4'(STABLE_CYCLES - 1));
    assign accept  = matured && (cand != accepted) && (state == IDLE);

    always_comb begin
        next_state     = state;
        push           = 1'b0;
        push_data.code = accepted;
        push_data.make = 1'b1;
        case (state)
            IDLE: begin
                if (accept) begin
                    next_state = (accepted != 8'h00) ? REL : PRS;
                end
            end
            REL: begin
                push           = 1'b1;
                push_data.code = prev_code;
                push_data.make = 1'b0;
                next_state     = (accepted != 8'h00) ? PRS : IDLE;
            end
            PRS: begin
                push       = 1'b1;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state     <= IDLE;
            cand      <= 8'h00;
            cnt       <= 4'd0;
            accepted  <= 8'h00;
            prev_code <= 8'h00;
            last_code <= 8'h00;
            overflow  <= 1'b0;
        end else begin
            state <= next_state;
            cand  <= keycode;
            cnt   <= cnt_next;
            if (accept) begin
                prev_code <= accepted;
                accepted  <= cand;
            end
            if (state == PRS) begin
                last_code <= accepted;
            end
            if (dropped) begin
                overflow <= 1'b1;
            end else if (clr_overflow) begin
                overflow <= 1'b0;
            end
        end
    end

    // The FSM never stalls; a push that finds no room is simply lost.
    assign pop     = ev.ev_valid && ev.ev_ready;
    assign dropped = push && full && !pop;

    event_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (Clk),
        .rst_n     (Reset_n),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .head      (head),
        .full      (full),
        .empty     (empty),
        .count     (count)
    );

    assign ev.ev_valid = !empty;
    assign ev.ev_code  = head.code;
    assign ev.ev_make  = head.make;

endmodule

// File: tb/tb_keycode_event_queue.sv
// Directed bench for keycode_event_queue with default parameters.
module tb_keycode_event_queue;

    logic       Clk;
    logic       Reset_n;
    logic [7:0] keycode;
    logic [4:0] count;
    logic       overflow;
    logic       clr_overflow;
    logic [7:0] last_code;

    int errors = 0;
    int checks = 0;

    logic [7:0] fill_codes [6] = '{8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h00};
    logic [8:0] drain_heads [8] = '{
        {8'h11, 1'b1}, {8'h11, 1'b0}, {8'h22, 1'b1}, {8'h22, 1'b0},
        {8'h33, 1'b1}, {8'h33, 1'b0}, {8'h44, 1'b1}, {8'h55, 1'b0}
    };

    keycode_event_queue_if ev_bus ();

    keycode_event_queue dut (
        .Clk          (Clk),
        .Reset_n      (Reset_n),
        .keycode      (keycode),
        .ev           (ev_bus),
        .count        (count),
        .overflow     (overflow),
        .clr_overflow (clr_overflow),
        .last_code    (last_code)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick(input int n);
        repeat (n) @(negedge Clk);
    endtask

    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic check_head(input string tag, input logic [8:0] expected);
        check_output({tag, "_valid"}, 32'(ev_bus.ev_valid), 32'd1);
        check_output({tag, "_head"}, 32'({ev_bus.ev_code, ev_bus.ev_make}), 32'(expected));
    endtask

    initial begin
        Reset_n         = 1'b0;
        keycode         = 8'h00;
        clr_overflow    = 1'b0;
        ev_bus.ev_ready = 1'b0;
        tick(2);
        check_output("rst_count", 32'(count), 32'd0);
        check_output("rst_valid", 32'(ev_bus.ev_valid), 32'd0);
        check_output("rst_overflow", 32'(overflow), 32'd0);
        check_output("rst_last_code", 32'(last_code), 32'h00);

        // Idle zero keycode through reset release
        Reset_n = 1'b1;
        tick(10);
        check_output("idle_zero_count", 32'(count), 32'd0);

        // Press latency: no event through edge 4, event after edge 5
        keycode = 8'h1A;
        tick(4);
        check_output("press_e4_valid", 32'(ev_bus.ev_valid), 32'd0);
        check_output("press_e4_last", 32'(last_code), 32'h00);
        tick(1);
        check_head("press_e5", {8'h1A, 1'b1});
        check_output("press_count", 32'(count), 32'd1);
        check_output("press_last", 32'(last_code), 32'h1A);
        tick(1);

        // Release
        keycode = 8'h00;
        tick(4);
        check_output("rel_e4_count", 32'(count), 32'd1);
        tick(2);
        check_output("rel_count", 32'(count), 32'd2);
        check_output("rel_last", 32'(last_code), 32'h1A);

        ev_bus.ev_ready = 1'b1;
        check_head("pop_1a_make", {8'h1A, 1'b1});
        tick(1);
        check_head("pop_1a_break", {8'h1A, 1'b0});
        check_output("pop_mid_count", 32'(count), 32'd1);
        tick(1);
        check_output("pop_done_valid", 32'(ev_bus.ev_valid), 32'd0);
        tick(1);
        check_output("ready_empty_count", 32'(count), 32'd0);
        ev_bus.ev_ready = 1'b0;

        // Glitch rejection
        keycode = 8'h2C;
        tick(2);
        keycode = 8'h00;
        tick(8);
        check_output("glitch_count", 32'(count), 32'd0);
        check_output("glitch_valid", 32'(ev_bus.ev_valid), 32'd0);

        // Key change 04 -> 07
        keycode = 8'h04;
        tick(7);
        check_output("kc_04_count", 32'(count), 32'd1);
        keycode = 8'h07;
        tick(5);
        check_output("kc_rel_count", 32'(count), 32'd2);
        tick(1);
        check_output("kc_prs_count", 32'(count), 32'd3);
        check_output("kc_last", 32'(last_code), 32'h07);
        ev_bus.ev_ready = 1'b1;
        check_head("kc_h0", {8'h04, 1'b1});
        tick(1);
        check_head("kc_h1", {8'h04, 1'b0});
        tick(1);
        check_head("kc_h2", {8'h07, 1'b1});
        tick(1);
        check_output("kc_drained", 32'(count), 32'd0);
        ev_bus.ev_ready = 1'b0;

        // Overflow: 9 events into 8 slots, then a 10th with clr_overflow held
        for (int i = 0; i < 6; i++) begin
            keycode = fill_codes[i];
            tick(7);
        end
        check_output("ovf_count", 32'(count), 32'd8);
        check_output("ovf_flag", 32'(overflow), 32'd1);
        keycode      = 8'h55;
        clr_overflow = 1'b1;
        tick(4);
        check_output("ovf_cleared", 32'(overflow), 32'd0);
        tick(1);
        check_output("ovf_clr_and_drop", 32'(overflow), 32'd1);
        check_output("ovf_last", 32'(last_code), 32'h55);
        tick(2);
        clr_overflow = 1'b0;
        tick(1);
        check_output("ovf_count_still", 32'(count), 32'd8);
        check_head("ovf_head", {8'h07, 1'b0});
        clr_overflow = 1'b1;
        tick(1);
        clr_overflow = 1'b0;
        check_output("ovf_clear_pulse", 32'(overflow), 32'd0);

        // Full boundary: push and pop on the same edge
        keycode = 8'h00;
        tick(4);
        ev_bus.ev_ready = 1'b1;
        tick(1);
        ev_bus.ev_ready = 1'b0;
        check_output("full_pp_count", 32'(count), 32'd8);
        check_output("full_pp_overflow", 32'(overflow), 32'd0);
        ev_bus.ev_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            check_head($sformatf("drain_%0d", i), drain_heads[i]);
            tick(1);
        end
        check_output("drain_count", 32'(count), 32'd0);
        ev_bus.ev_ready = 1'b0;

        // Reset while in PRS
        keycode = 8'h3F;
        tick(7);
        check_output("pre_rst_count", 32'(count), 32'd1);
        keycode = 8'h4A;
        tick(5);
        check_output("pre_rst_rel_count", 32'(count), 32'd2);
        Reset_n = 1'b0;
        keycode = 8'h00;
        #1;
        check_output("mid_rst_count", 32'(count), 32'd0);
        check_output("mid_rst_valid", 32'(ev_bus.ev_valid), 32'd0);
        check_output("mid_rst_last", 32'(last_code), 32'h00);
        tick(3);
        Reset_n = 1'b1;
        tick(10);
        check_output("post_rst_count", 32'(count), 32'd0);
        check_output("post_rst_last", 32'(last_code), 32'h00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/keycode_event_queue.md
KEYCODE_EVENT_QUEUE -- requirements
Module: keycode_event_queue

Interface
REQ-001 SHALL have parameter STABLE_CYCLES, default 4; consecutive equal keycode samples required to accept a new code (range 1..15).
REQ-002 SHALL have parameter DEPTH, default 8; event FIFO entries, power of 2 (range 2..16).
REQ-003 SHALL have port Clk, input, 1; the single clock; all state updates on its rising edge.
REQ-004 SHALL have port Reset_n, input, 1; asynchronous, active-low reset.
REQ-005 SHALL have port keycode, input, 8; current USB keycode from the SoC keycode PIO, same clock domain; 8'h00 means no key.
REQ-006 SHALL have port ev_valid, output, 1; FIFO head holds an event.
REQ-007 SHALL have port ev_ready, input, 1; consumer accepts the head event.
REQ-008 SHALL have port ev_code, output, 8; keycode of the head event.
REQ-009 SHALL have port ev_make, output, 1; 1 = press, 0 = release, for the head event.
REQ-010 SHALL have port count, output, 5; FIFO occupancy, 0..DEPTH.
REQ-011 SHALL have port overflow, output, 1; sticky, set when an event is dropped.
REQ-012 SHALL have port clr_overflow, input, 1; clears overflow.
REQ-013 SHALL have port last_code, output, 8; most recent pressed keycode, for the hex display.

Function
REQ-014 Filter SHALL register keycode into cand each cycle; cnt resets to 0 on keycode != cand, else increments, saturating at STABLE_CYCLES.
REQ-015 When cnt reaches STABLE_CYCLES-1 with keycode == cand, cand != accepted and the FSM is in IDLE, accepted SHALL load cand and the FSM SHALL leave IDLE on the same edge; otherwise acceptance is deferred, not lost.
REQ-016 FSM states SHALL be IDLE, REL and PRS; each non-IDLE state lasts exactly one cycle and pushes one event.
REQ-017 On acceptance old->new: old != 0 -> REL; old == 0 -> PRS.
REQ-018 REL SHALL push {old, make=0}, then go to PRS if new != 0, else to IDLE.
REQ-019 PRS SHALL push {new, make=1}, load last_code <= new, then go to IDLE.
REQ-020 A push into a full FIFO without a same-cycle pop SHALL drop the event and set overflow; the FSM still advances (no backpressure to the filter).
REQ-021 FIFO SHALL be first-word-fallthrough: ev_valid = (count != 0); ev_code and ev_make show the head combinationally from registers.
REQ-022 A pop SHALL occur on any edge with ev_valid && ev_ready; ev_ready while empty has no effect.
REQ-023 Simultaneous push and pop SHALL leave count unchanged, including when full; no drop and no overflow in that case.
REQ-024 Read and write pointers SHALL wrap modulo DEPTH; count SHALL never exceed DEPTH or go below 0.
REQ-025 With default STABLE_CYCLES = 4 and an empty FIFO: keycode changes before edge 1 and is held; the first event is pushed at edge 5; ev_valid is high after edge 5.
REQ-026 When clr_overflow and a drop occur in the same cycle, overflow SHALL remain 1.
REQ-027 A return to the current accepted code before cnt matures SHALL produce no event.

Reset
REQ-028 Reset_n low SHALL asynchronously clear cand, cnt, accepted, pointers, count, overflow and last_code to 0 and set the FSM to IDLE.
REQ-029 Reset SHALL discard FIFO contents; with ev_valid = 0, ev_code and ev_make are don't-care.
REQ-030 Reset asserted mid-sequence (REL or PRS) SHALL abort it with no partial push.
REQ-031 A keycode held at 8'h00 through reset release SHALL produce no event.

Structure
REQ-032 Package keycode_pkg SHALL hold the event struct {code[7:0], make}, the FSM state enum and the default parameter constants.
REQ-033 The FIFO SHALL be a sub-module named event_fifo (parameter DEPTH, push/pop/full/empty/count).
REQ-034 The filter and the FSM SHALL reside in keycode_event_queue.

Verification
REQ-035 Press and release: keycode 00->1A held 6 cycles, then 00 held 6 cycles, ev_ready = 1 -> events {1A,1} then {1A,0}; last_code = 1A.
REQ-036 Key change: keycode 04->07 with both held -> {04,0} then {07,1} on consecutive edges.
REQ-037 Glitch rejection: 2-cycle pulse of 2C from 00 -> no event; count stays 0.
REQ-038 Overflow: ev_ready = 0, generate 10 events into DEPTH 8 -> count = 8; overflow = 1; first 8 events retained in order; clr_overflow -> overflow = 0.
REQ-039 Full boundary: FIFO full, push and pop on the same edge -> count stays 8; overflow stays 0.
REQ-040 Reset during PRS -> count = 0, ev_valid = 0, last_code = 00 immediately, without a clock edge.
